// File: rtl/w_pipe_reg.sv
// W pipeline register for the PIPE Y86-64 core: write-back fields, run-state FSM.
// Define RETIRE_COUNTER_EN to build the retired-instruction counter.
module w_pipe_reg #(
  parameter int          CNT_W = 32,
  parameter logic [3:0]  RNONE = 4'hF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       M_stat,
  input  logic [3:0]       M_icode,
  input  logic [63:0]      M_valE,
  input  logic [63:0]      m_valM,
  input  logic [3:0]       M_dstE,
  input  logic [3:0]       M_dstM,
  input  logic             dmem_error,
  input  logic             W_stall,
  input  logic             W_bubble,
  output logic [2:0]       W_stat,
  output logic [3:0]       W_icode,
  output logic [63:0]      W_valE,
  output logic [63:0]      W_valM,
  output logic [3:0]       W_dstE,
  output logic [3:0]       W_dstM,
  output logic             wbE_en,
  output logic             wbM_en,
  output logic [1:0]       cpu_state,
  output logic [CNT_W-1:0] retired
);

  localparam logic [2:0] S_BUB = 3'd0;
  localparam logic [2:0] S_AOK = 3'd1;
  localparam logic [2:0] S_HLT = 3'd2;
  localparam logic [2:0] S_ADR = 3'd3;
  localparam logic [2:0] S_INS = 3'd4;
  localparam logic [3:0] I_NOP = 4'h1;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    HALTED = 2'd1,
    FAULT  = 2'd2
  } state_e;

  state_e state_q;
  state_e state_d;

  logic        run;
  logic        load;
  logic [2:0]  m_stat;
  logic [2:0]  ld_stat;
  logic [3:0]  ld_icode;
  logic [63:0] ld_valE;
  logic [63:0] ld_valM;
  logic [3:0]  ld_dstE;
  logic [3:0]  ld_dstM;

  assign m_stat = dmem_error ? S_ADR : M_stat;
  assign run    = (state_q == RUN);
  // Stall beats bubble; a frozen pipeline loads nothing.
  assign load   = run && !W_stall;

  always_comb begin
    ld_stat  = m_stat;
    ld_icode = M_icode;
    ld_valE  = M_valE;
    ld_valM  = m_valM;
    ld_dstE  = M_dstE;
    ld_dstM  = M_dstM;
    unique case (1'b1)
      W_bubble: begin
        ld_stat  = S_BUB;
        ld_icode = I_NOP;
        ld_valE  = '0;
        ld_valM  = '0;
        ld_dstE  = RNONE;
        ld_dstM  = RNONE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      W_stat  <= S_BUB;
      W_icode <= I_NOP;
      W_valE  <= '0;
      W_valM  <= '0;
      W_dstE  <= RNONE;
      W_dstM  <= RNONE;
    end else if (load) begin
      W_stat  <= ld_stat;
      W_icode <= ld_icode;
      W_valE  <= ld_valE;
      W_valM  <= ld_valM;
      W_dstE  <= ld_dstE;
      W_dstM  <= ld_dstM;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= RUN;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN: begin
        if (load && ld_stat == S_HLT)
          state_d = HALTED;
        else if (load && (ld_stat == S_ADR ||
                          ld_stat == S_INS))
          state_d = FAULT;
      end
      default: state_d = state_q;
    endcase
  end

  always_comb begin
    cpu_state = state_q;
    wbE_en = (W_dstE != RNONE) &&
             (W_stat == S_AOK) && run;
    wbM_en = (W_dstM != RNONE) &&
             (W_stat == S_AOK) && run;
  end

`ifdef RETIRE_COUNTER_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset)
      cnt_q <= '0;
    else if (load && ld_stat == S_AOK &&
             ld_icode != I_NOP)
      cnt_q <= cnt_q + CNT_W'(1);
  end

  assign retired = cnt_q;
`else
  assign retired = '0;
`endif

endmodule
